// File: rtl/mini_pe_tile_accum.sv
// Sums KTILES partial 2x2 results from the mini PE array into one output tile and tracks the peak importance.
// Optional build macro MINI_ACCUM_SAT_EN selects clamping accumulators; otherwise they wrap.
module mini_pe_tile_accum #(
    parameter int width  = 8,
    parameter int ACC_W  = 24,
    parameter int KTILES = 4
) (
    input  logic                      clk,
    input  logic                      _reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic signed [2*width-1:0] result0,
    input  logic signed [2*width-1:0] result1,
    input  logic signed [2*width-1:0] result2,
    input  logic signed [2*width-1:0] result3,
    input  logic        [2*width-1:0] importance,
    output logic signed [ACC_W-1:0]   acc0,
    output logic signed [ACC_W-1:0]   acc1,
    output logic signed [ACC_W-1:0]   acc2,
    output logic signed [ACC_W-1:0]   acc3,
    output logic        [2*width-1:0] max_imp,
    output logic        [3:0]         max_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      drop,
    output logic                      sat
);
    localparam int DW = 2 * width;
    localparam logic [3:0] LAST = 4'(KTILES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              count_q, count_d;
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic [DW-1:0]           max_imp_q, max_imp_d;
    logic [3:0]              max_idx_q, max_idx_d;
    logic                    sat_q, sat_d;
    logic                    drop_q, drop_d;

    logic signed [DW-1:0]    res [4];
    logic signed [ACC_W-1:0] sum [4];
    logic [3:0]              clamp;
    logic                    do_clear, do_accept;

    assign res[0] = result0;
    assign res[1] = result1;
    assign res[2] = result2;
    assign res[3] = result3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
`ifdef MINI_ACCUM_SAT_EN
            localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
            logic signed [ACC_W:0] wide;
            // One guard bit: the top two bits differ exactly when the ACC_W-bit sum overflowed.
            assign wide      = {acc_q[gi][ACC_W-1], acc_q[gi]}
                             + {{(ACC_W+1-DW){res[gi][DW-1]}}, res[gi]};
            assign clamp[gi] = wide[ACC_W] ^ wide[ACC_W-1];
            assign sum[gi]   = clamp[gi] ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];
`else
            assign clamp[gi] = 1'b0;
            assign sum[gi]   = acc_q[gi] + {{(ACC_W-DW){res[gi][DW-1]}}, res[gi]};
`endif
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        drop_d    = 1'b0;
        do_clear  = 1'b0;
        do_accept = 1'b0;
        case (state_q)
            IDLE: begin
                drop_d = in_valid;
                if (start) begin
                    do_clear = 1'b1;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (start) begin
                    do_clear = 1'b1;
                    drop_d   = in_valid;
                end else if (in_valid) begin
                    do_accept = 1'b1;
                    if (count_q == LAST) state_d = HOLD;
                end
            end
            HOLD: begin
                drop_d = in_valid;
                if (out_ready) begin
                    if (start) begin
                        do_clear = 1'b1;
                        state_d  = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        max_imp_d = max_imp_q;
        max_idx_d = max_idx_q;
        sat_d     = sat_q;
        if (do_clear) begin
            count_d   = '0;
            for (int i = 0; i < 4; i++) acc_d[i] = '0;
            max_imp_d = '0;
            max_idx_d = '0;
            sat_d     = 1'b0;
        end else if (do_accept) begin
            for (int i = 0; i < 4; i++) acc_d[i] = sum[i];
            // The first beat always loads, so a tile of all-zero importance still reports index 0.
            if (count_q == 4'd0 || importance > max_imp_q) begin
                max_imp_d = importance;
                max_idx_d = count_q;
            end
            count_d = count_q + 4'd1;
            sat_d   = sat_q | (|clamp);
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
            max_imp_q <= '0;
            max_idx_q <= '0;
            sat_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            max_imp_q <= max_imp_d;
            max_idx_q <= max_idx_d;
            sat_q     <= sat_d;
            drop_q    <= drop_d;
        end
    end

    assign acc0      = acc_q[0];
    assign acc1      = acc_q[1];
    assign acc2      = acc_q[2];
    assign acc3      = acc_q[3];
    assign max_imp   = max_imp_q;
    assign max_idx   = max_idx_q;
    assign sat       = sat_q;
    assign drop      = drop_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == ACCUM);
endmodule
